// File: rtl/fp_multiplier.sv
// Two-stage pipelined IEEE-754 multiplier: stage 1 unpacks and multiplies, stage 2
// normalises, rounds to nearest-even and packs. Subnormals in and out are flushed to zero.
module fp_multiplier #(
  parameter int PRECISION = 32,
  parameter int EXPONENT  = 8,
  parameter int FRACTION  = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PRECISION-1:0] a_operand,
  input  logic [PRECISION-1:0] b_operand,
  output logic [PRECISION-1:0] result
);

  localparam int EW = EXPONENT + 2;
  localparam int MW = 2 * (FRACTION + 1);
  localparam int SW = FRACTION + 2;

  localparam logic signed [EW-1:0] BIAS      = EW'((1 << (EXPONENT - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXPONENT) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO  = '0;
  localparam logic [PRECISION-1:0] QNAN      = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};

  // ---------------- stage 1: unpack, classify, exponent sum, mantissa product
  logic                 sa, sb;
  logic [EXPONENT-1:0]  ea, eb;
  logic [FRACTION-1:0]  fa, fb;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  logic                 sign_d, sign_q;
  logic signed [EW-1:0] exp_d, exp_q;
  logic [MW-1:0]        mant_d, mant_q;
  logic                 nan_d, nan_q;
  logic                 inf_d, inf_q;
  logic                 zero_d, zero_q;

  always_comb begin
    sa = a_operand[PRECISION-1];
    sb = b_operand[PRECISION-1];
    ea = a_operand[PRECISION-2 -: EXPONENT];
    eb = b_operand[PRECISION-2 -: EXPONENT];
    fa = a_operand[FRACTION-1:0];
    fb = b_operand[FRACTION-1:0];

    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    // A zero exponent field covers both true zeros and subnormals, which are flushed.
    a_zero = ~(|ea);
    b_zero = ~(|eb);

    nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    inf_d  = (a_inf | b_inf) & ~nan_d;
    zero_d = (a_zero | b_zero) & ~nan_d & ~inf_d;

    sign_d = sa ^ sb;
    exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    mant_d = MW'({1'b1, fa}) * MW'({1'b1, fb});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
      nan_q  <= 1'b0;
      inf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      mant_q <= mant_d;
      nan_q  <= nan_d;
      inf_q  <= inf_d;
      zero_q <= zero_d;
    end
  end

  // ---------------- stage 2: normalise, round, pack
  logic [MW-1:0]        norm;
  logic signed [EW-1:0] exp_norm, exp_rnd;
  logic [FRACTION:0]    sig;
  logic                 guard, sticky, round_up;
  logic [SW-1:0]        sig_r;
  logic [FRACTION-1:0]  frac_out;
  logic [PRECISION-1:0] result_d, result_q;

  always_comb begin
    // Product of two [1,2) significands lies in [1,4); align the leading one to the top bit.
    norm     = mant_q[MW-1] ? mant_q : (mant_q << 1);
    exp_norm = exp_q + EW'(mant_q[MW-1]);

    sig      = norm[MW-1 -: FRACTION+1];
    guard    = norm[FRACTION];
    sticky   = |norm[FRACTION-1:0];
    round_up = guard & (sticky | sig[0]);
    sig_r    = {1'b0, sig} + SW'(round_up);

    // A carry out of rounding leaves 10.000..0, so the fraction becomes zero.
    if (sig_r[SW-1]) begin
      frac_out = sig_r[FRACTION:1];
      exp_rnd  = exp_norm + EW'(1);
    end else begin
      frac_out = sig_r[FRACTION-1:0];
      exp_rnd  = exp_norm;
    end

    if (nan_q) begin
      result_d = QNAN;
    end else if (inf_q) begin
      result_d = {sign_q, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
    end else if (zero_q) begin
      result_d = {sign_q, {(PRECISION-1){1'b0}}};
    end else if (exp_rnd >= EXP_MAX) begin
      result_d = {sign_q, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
    end else if (exp_rnd <= EXP_ZERO) begin
      result_d = {sign_q, {(PRECISION-1){1'b0}}};
    end else begin
      result_d = {sign_q, exp_rnd[EXPONENT-1:0], frac_out};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_fp_multiplier.sv
// Directed-vector bench for fp_multiplier: single-precision table streamed back-to-back,
// reset corner sequences, and a double-precision instance.
module tb_fp_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b, result;
  logic [63:0] a64, b64, result64;

  always #5 clk = ~clk;

  fp_multiplier dut (
    .clk       (clk),
    .reset     (reset),
    .a_operand (a),
    .b_operand (b),
    .result    (result)
  );

  fp_multiplier #(
    .PRECISION (64),
    .EXPONENT  (11),
    .FRACTION  (52)
  ) dut64 (
    .clk       (clk),
    .reset     (reset),
    .a_operand (a64),
    .b_operand (b64),
    .result    (result64)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [63:0] exp64_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] e;
  string       n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic add_vec(input string nm, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ev);
    vec_t v;
    v.name  = nm;
    v.a     = av;
    v.b     = bv;
    v.exp_r = ev;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    add_vec("half_x_neg",     32'h3F000000, 32'hBEE00000, 32'hBE600000);
    add_vec("neg_x_neg",      32'hC0200000, 32'hBFC00000, 32'h40700000);
    add_vec("pos_x_neg",      32'h40500000, 32'hBFC00000, 32'hC09C0000);
    add_vec("ten_x_half",     32'h41200000, 32'h3F000000, 32'h40A00000);
    add_vec("round_a",        32'h3E0A7EFA, 32'hBF032F45, 32'hBD8DF119);
    add_vec("round_b",        32'h3AA3D70A, 32'h3A449BA6, 32'h357BA882);
    add_vec("tie_up_odd",     32'h3FC00000, 32'h3F800001, 32'h3FC00002);
    add_vec("tie_keep_even",  32'h3F800003, 32'h3FC00000, 32'h3FC00004);
    add_vec("round_carry",    32'h3F800001, 32'h3F7FFFFE, 32'h3F800000);
    add_vec("inf_x_zero",     32'h7F800000, 32'h00000000, 32'h7FC00000);
    add_vec("zero_x_inf",     32'h00000000, 32'hFF800000, 32'h7FC00000);
    add_vec("inf_x_neg1",     32'h7F800000, 32'hBF800000, 32'hFF800000);
    add_vec("inf_x_inf",      32'hFF800000, 32'hFF800000, 32'h7F800000);
    add_vec("negzero_x_two",  32'h80000000, 32'h40000000, 32'h80000000);
    add_vec("qnan_a",         32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    add_vec("snan_x_zero",    32'hFF800001, 32'h00000000, 32'h7FC00000);
    add_vec("nan_b_neg",      32'h3F800000, 32'hFFFFFFFF, 32'h7FC00000);
    add_vec("inf_x_nan",      32'h7F800000, 32'h7FA00000, 32'h7FC00000);
    add_vec("overflow",       32'h7F000000, 32'h40000000, 32'h7F800000);
    add_vec("overflow_neg",   32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFF800000);
    add_vec("max_normal",     32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF);
    add_vec("min_normal",     32'h00800000, 32'h3F800000, 32'h00800000);
    add_vec("underflow",      32'h00800000, 32'h3F000000, 32'h00000000);
    add_vec("underflow_neg",  32'h80800000, 32'h3F000000, 32'h80000000);
    add_vec("subnormal_in",   32'h00400000, 32'hBF800000, 32'h80000000);

    // Reset held two cycles with live operands: output must stay cleared.
    reset = 1'b1;
    a     = 32'h3F800000;
    b     = 32'h40000000;
    a64   = '0;
    b64   = '0;
    repeat (2) begin
      tick();
      check("reset_hold", {32'h0, result}, 64'h0);
    end

    // Release and stream the table one pair per cycle; each product appears two edges later.
    reset = 1'b0;
    for (int k = 0; k <= vecs.size(); k++) begin
      if (k < vecs.size()) begin
        a = vecs[k].a;
        b = vecs[k].b;
        exp_q.push_back(vecs[k].exp_r);
        name_q.push_back(vecs[k].name);
      end else begin
        a = '0;
        b = '0;
      end
      tick();
      if (k == 0) begin
        check("first_after_release", {32'h0, result}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, {32'h0, result}, {32'h0, e});
      end
    end

    // Reset with products in flight: both are dropped, then the pipe resumes cleanly.
    a = 32'h40000000; b = 32'h40000000;
    tick();
    a = 32'h3F800000; b = 32'h3FC00000;
    tick();
    check("rst_mid_pre", {32'h0, result}, 64'h0000000040800000);
    reset = 1'b1;
    tick();
    check("rst_mid_clear", {32'h0, result}, 64'h0);
    reset = 1'b0;
    a = 32'hC0000000; b = 32'h3F000000;
    tick();
    check("rst_mid_flushed", {32'h0, result}, 64'h0);
    a = '0; b = '0;
    tick();
    check("rst_mid_resume", {32'h0, result}, 64'h00000000BF800000);

    // Double-precision instance, streamed back-to-back.
    a64 = 64'h4004000000000000; b64 = 64'hBFF8000000000000;
    exp64_q.push_back(64'hC00E000000000000);
    tick();
    a64 = 64'h7FF0000000000001; b64 = 64'h3FF0000000000000;
    exp64_q.push_back(64'h7FF8000000000000);
    tick();
    check("dp_mul", result64, exp64_q.pop_front());
    a64 = 64'h7FE0000000000000; b64 = 64'h4000000000000000;
    exp64_q.push_back(64'h7FF0000000000000);
    tick();
    check("dp_nan", result64, exp64_q.pop_front());
    a64 = 64'h3FF8000000000000; b64 = 64'h3FF0000000000001;
    exp64_q.push_back(64'h3FF8000000000002);
    tick();
    check("dp_overflow", result64, exp64_q.pop_front());
    a64 = '0; b64 = '0;
    tick();
    check("dp_tie_up", result64, exp64_q.pop_front());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_multiplier.md
Name: fp_multiplier

Overview:
- Parameterised IEEE-754 binary floating-point multiplier: result = a_operand × b_operand.
- Default format is single precision (32-bit). The same RTL must also build for double precision (64/11/52).
- Free-running pipelined datapath used inside the chaos-map arithmetic of the image-encryption core.
- Accepts a new operand pair every clock. No handshake.

Parameters:
- PRECISION, 32: total word width.
- EXPONENT, 8: exponent field width. Bias = 2^(EXPONENT-1)-1.
- FRACTION, 23: stored fraction width. PRECISION = 1 + EXPONENT + FRACTION.

Ports:
- clk  input  1  rising-edge clock; only clock domain.
- reset  input  1  synchronous, active-high reset.
- a_operand  input  PRECISION  IEEE-754 operand A, raw bit pattern.
- b_operand  input  PRECISION  IEEE-754 operand B, raw bit pattern.
- result  output  PRECISION  IEEE-754 product, registered.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - While reset=1 at a rising edge, all pipeline registers and result are cleared to 0.
  - Reset mid-operation discards all in-flight products.
  - The first valid result appears 2 edges after the first edge with reset=0.
- Latency and throughput:
  - Fixed 2-cycle latency. Operands sampled at edge N produce result at edge N+2.
  - Throughput is one product per cycle. There is no stall.
- Stage 1 (registered):
  - Unpack fields.
  - sign = sa XOR sb.
  - Exponent sum ea+eb-bias, kept at EXPONENT+2 bits signed to detect overflow and underflow.
  - Mantissa product (1.fa)×(1.fb), 2·(FRACTION+1) bits.
  - Special-case flags.
- Stage 2 (registered):
  - Normalise: if product bit[2F+1] is set, shift right 1 and increment the exponent.
  - Round to nearest, ties to even, using guard and sticky bits.
  - If rounding carries out of the mantissa, renormalise and increment the exponent.
  - Pack the result.
- Subnormal inputs (exp=0, frac≠0) are treated as zero.
- Results below the minimum normal flush to signed zero. No subnormal outputs.
- Special cases, in priority order:
  - Either operand NaN → canonical quiet NaN: sign 0, exp all-1, MSB of fraction 1, rest 0 (0x7FC00000 for 32-bit).
  - Inf × zero → canonical quiet NaN.
  - Inf × finite nonzero → inf with the product sign.
  - Zero × finite → zero with the product sign.
- Overflow: a biased exponent ≥ all-ones after rounding produces signed infinity.
- All arithmetic is width-parameterised; no hard-coded 32-bit constants.

Test Plan:
- Reset held 2 cycles, then released → result=0x00000000 during reset. First product appears at release+2 cycles.
- Back-to-back operand pairs, one per cycle, each result 2 cycles after its operands:
  - 0x3F000000 × 0xBEE00000 → 0xBE600000 (0.5 × -0.4375 = -0.21875).
  - 0xC0200000 × 0xBFC00000 → 0x40700000 (3.75).
  - 0x40500000 × 0xBFC00000 → 0xC09C0000 (-4.875).
  - 0x41200000 × 0x3F000000 → 0x40A00000 (5.0).
- Rounding check: 0x3E0A7EFA × 0xBF032F45 → product matches the IEEE round-to-nearest-even reference model bit-exactly. Repeat for 0x3AA3D70A × 0x3A449BA6.
- Special values:
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0x7F800000 × 0xBF800000 → 0xFF800000.
  - 0x80000000 × 0x40000000 → 0x80000000.
  - Any NaN input → 0x7FC00000.
- Overflow and underflow:
  - 0x7F000000 × 0x40000000 → 0x7F800000.
  - 0x00800000 × 0x3F000000 → 0x00000000 (flush).
- Assert reset mid-stream with two products in flight → both discarded. result=0 on the edge after reset assertion.
- PRECISION=64/EXPONENT=11/FRACTION=52 build: 0x4004000000000000 × 0xBFF8000000000000 → 0xC00E000000000000 (2.5 × -1.5 = -3.75).
